// File: rtl/xgmii_baser_enc_64.sv
// xgmii_baser_enc_64 -- 10GBASE-R 64b/66b block encoder. It takes one 64-bit XGMII word
// per cycle and produces the unscrambled 64b/66b payload and its sync header.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   xgmii_txd        XGMII data; lane n is in bits [8n+7:8n]
//   xgmii_txc        XGMII control; bit n marks lane n as a control character
//   encoded_tx_data  block payload; the block type is in [7:0] for control blocks
//   encoded_tx_hdr   sync header: 2'b01 = data block, 2'b10 = control block
//   tx_bad_block     high for one cycle when the word had no legal encoding
//
// Latency is exactly one cycle, and a new word is accepted every cycle.
// Encoding rules:
//   - A 7-bit control code for lane i always sits at [8+7i +: 7]. The block types
//     0x1E, 0x33, 0x2D, 0x4B and terminate all use these slots, so the code fields
//     for terminate blocks end at bit 63 without extra shifting.
//   - A data byte for lane i sits at byte i+1 for lanes below a terminate, and at
//     its native position for lanes 5..7 of the split-block types.
module xgmii_baser_enc_64 #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] xgmii_txd,
    input  logic [CTRL_WIDTH-1:0] xgmii_txc,
    output logic [DATA_WIDTH-1:0] encoded_tx_data,
    output logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    output logic                  tx_bad_block
);

    if (DATA_WIDTH != 64) begin : g_bad_dw
        $fatal(1, "xgmii_baser_enc_64: DATA_WIDTH must be 64");
    end
    if (HDR_WIDTH != 2) begin : g_bad_hw
        $fatal(1, "xgmii_baser_enc_64: HDR_WIDTH must be 2");
    end

    localparam logic [7:0] START = 8'hFB;
    localparam logic [7:0] TERM  = 8'hFD;

    // The returned value is {valid, 7-bit code}.
    function automatic logic [7:0] ctl_map(input logic [7:0] b);
        case (b)
            8'h07:   return {1'b1, 7'h00};
            8'hFE:   return {1'b1, 7'h1E};
            8'h1C:   return {1'b1, 7'h2D};
            8'h3C:   return {1'b1, 7'h33};
            8'h7C:   return {1'b1, 7'h4B};
            8'hBC:   return {1'b1, 7'h55};
            8'hDC:   return {1'b1, 7'h66};
            8'hF7:   return {1'b1, 7'h78};
            default: return 8'h00;
        endcase
    endfunction

    // The returned value is {valid, 4-bit O code}.
    function automatic logic [4:0] oset_map(input logic [7:0] b);
        case (b)
            8'h9C:   return {1'b1, 4'h0};
            8'h5C:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    logic [7:0] lane [8];
    logic [6:0] c    [8];
    logic       cv   [8];
    logic [3:0] o    [8];
    logic       ov   [8];

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            lane[i]        = xgmii_txd[8*i +: 8];
            {cv[i], c[i]}  = ctl_map(lane[i]);
            {ov[i], o[i]}  = oset_map(lane[i]);
        end
    end

    logic        c0_3_ok, c4_7_ok, all_c_ok;
    logic        term_hit, tail_ok;
    logic [2:0]  term_k;
    logic [63:0] nxt_data;
    logic [1:0]  nxt_hdr;
    logic        nxt_bad;

    assign c0_3_ok  = cv[0] & cv[1] & cv[2] & cv[3];
    assign c4_7_ok  = cv[4] & cv[5] & cv[6] & cv[7];
    assign all_c_ok = c0_3_ok & c4_7_ok;

    // Terminate in lane k: txc must be a contiguous run of ones from bit k up to
    // bit 7, lane k must be /T/, and every lane after it must hold a legal code.
    always_comb begin
        term_hit = 1'b0;
        term_k   = 3'd0;
        tail_ok  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tail_ok = 1'b1;
            for (int j = 0; j < 8; j++)
                if (j > k && !cv[j]) tail_ok = 1'b0;
            if (xgmii_txc == (8'hFF << k) && lane[k] == TERM && tail_ok) begin
                term_hit = 1'b1;
                term_k   = 3'(k);
            end
        end
    end

    always_comb begin
        nxt_data = 64'h0;
        nxt_hdr  = 2'b10;
        nxt_bad  = 1'b0;
        if (xgmii_txc == 8'h00) begin
            nxt_hdr  = 2'b01;
            nxt_data = xgmii_txd;
        end else if (xgmii_txc == 8'hFF && all_c_ok) begin
            nxt_data[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++) nxt_data[8+7*i +: 7] = c[i];
        end else if (xgmii_txc == 8'h01 && lane[0] == START) begin
            nxt_data = {xgmii_txd[63:8], 8'h78};
        end else if (xgmii_txc == 8'h1F && c0_3_ok && lane[4] == START) begin
            nxt_data[7:0] = 8'h33;
            for (int i = 0; i < 4; i++) nxt_data[8+7*i +: 7] = c[i];
            nxt_data[63:40] = xgmii_txd[63:40];
        end else if (xgmii_txc == 8'h1F && c0_3_ok && ov[4]) begin
            nxt_data[7:0] = 8'h2D;
            for (int i = 0; i < 4; i++) nxt_data[8+7*i +: 7] = c[i];
            nxt_data[39:36] = o[4];
            nxt_data[63:40] = xgmii_txd[63:40];
        end else if (xgmii_txc == 8'h11 && ov[0] && lane[4] == START) begin
            nxt_data = {xgmii_txd[63:40], 4'h0, o[0], xgmii_txd[31:8], 8'h66};
        end else if (xgmii_txc == 8'h11 && ov[0] && ov[4]) begin
            nxt_data = {xgmii_txd[63:40], o[4], o[0], xgmii_txd[31:8], 8'h55};
        end else if (xgmii_txc == 8'hF1 && ov[0] && c4_7_ok) begin
            nxt_data[7:0]   = 8'h4B;
            nxt_data[31:8]  = xgmii_txd[31:8];
            nxt_data[35:32] = o[0];
            for (int i = 4; i < 8; i++) nxt_data[8+7*i +: 7] = c[i];
        end else if (term_hit) begin
            case (term_k)
                3'd0: nxt_data[7:0] = 8'h87;
                3'd1: nxt_data[7:0] = 8'h99;
                3'd2: nxt_data[7:0] = 8'hAA;
                3'd3: nxt_data[7:0] = 8'hB4;
                3'd4: nxt_data[7:0] = 8'hCC;
                3'd5: nxt_data[7:0] = 8'hD2;
                3'd6: nxt_data[7:0] = 8'hE1;
                default: nxt_data[7:0] = 8'hFF;
            endcase
            for (int i = 0; i < 8; i++) begin
                if (3'(i) < term_k)      nxt_data[8+8*i +: 8] = lane[i];
                else if (3'(i) > term_k) nxt_data[8+7*i +: 7] = c[i];
            end
        end else begin
            // The word has no legal encoding, so send an all-/E/ error block.
            nxt_bad       = 1'b1;
            nxt_data[7:0] = 8'h1E;
            for (int i = 0; i < 8; i++) nxt_data[8+7*i +: 7] = 7'h1E;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            encoded_tx_data <= 64'h1E;
            encoded_tx_hdr  <= 2'b10;
            tx_bad_block    <= 1'b0;
        end else begin
            encoded_tx_data <= nxt_data;
            encoded_tx_hdr  <= nxt_hdr;
            tx_bad_block    <= nxt_bad;
        end
    end

endmodule

// File: tb/tb_xgmii_baser_enc_64.sv
module tb_xgmii_baser_enc_64;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic [63:0] encoded_tx_data;
    logic [1:0]  encoded_tx_hdr;
    logic        tx_bad_block;

    int passed = 0;
    int total  = 0;

    localparam logic [63:0] ERR_BLK = 64'h3C78F1E3C78F1E1E;

    xgmii_baser_enc_64 dut (
        .clk             (clk),
        .rst             (rst),
        .xgmii_txd       (xgmii_txd),
        .xgmii_txc       (xgmii_txc),
        .encoded_tx_data (encoded_tx_data),
        .encoded_tx_hdr  (encoded_tx_hdr),
        .tx_bad_block    (tx_bad_block)
    );

    always #5 clk = ~clk;

    // Drive one word, let it be captured by the next edge, then sample just after that edge.
    task automatic apply(input logic [63:0] d, input logic [7:0] c);
        xgmii_txd = d;
        xgmii_txc = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] ed, input logic [1:0] eh,
                         input logic eb);
        total++;
        assert (encoded_tx_data === ed) passed++;
        else $error("FAIL %s data got %h want %h", tag, encoded_tx_data, ed);
        total++;
        assert (encoded_tx_hdr === eh) passed++;
        else $error("FAIL %s hdr got %b want %b", tag, encoded_tx_hdr, eh);
        total++;
        assert (tx_bad_block === eb) passed++;
        else $error("FAIL %s bad got %b want %b", tag, tx_bad_block, eb);
    endtask

    initial begin
        rst       = 1'b1;
        xgmii_txd = 64'h0;
        xgmii_txc = 8'h0;
        @(posedge clk);
        #1;
        // An invalid word presented during reset must not show up on the outputs.
        apply(64'h07070707070707AA, 8'hFF);
        check("reset", 64'h1E, 2'b10, 1'b0);
        rst = 1'b0;

        apply(64'h0707070707070707, 8'hFF);
        check("idle", 64'h1E, 2'b10, 1'b0);
        apply(64'hD5555555555555FB, 8'h01);
        check("start", 64'hD555555555555578, 2'b10, 1'b0);
        apply(64'h0011223344556677, 8'h00);
        check("data", 64'h0011223344556677, 2'b01, 1'b0);
        apply(64'h070707FD44332211, 8'hF0);
        check("term4", 64'h00000044332211CC, 2'b10, 1'b0);
        apply(64'h07070707070707AA, 8'hFF);
        check("bad_code", ERR_BLK, 2'b10, 1'b1);
        apply(64'h1122334455667788, 8'h03);
        check("bad_txc", ERR_BLK, 2'b10, 1'b1);
        apply(64'h0707070707070707, 8'hFF);
        check("idle_after_bad", 64'h1E, 2'b10, 1'b0);
        apply(64'h070707070000019C, 8'hF1);
        check("oset_4b", 64'h000000000000014B, 2'b10, 1'b0);
        apply(64'hCCBBAAFB07070707, 8'h1F);
        check("type33", 64'hCCBBAA0000000033, 2'b10, 1'b0);
        apply(64'hCCBBAAFB3322119C, 8'h11);
        check("type66", 64'hCCBBAA0033221166, 2'b10, 1'b0);
        apply(64'hCCBBAA9C3322115C, 8'h11);
        check("type55", 64'hCCBBAA0F33221155, 2'b10, 1'b0);
        apply(64'hCCBBAA5C070707FE, 8'h1F);
        check("type2d", 64'hCCBBAAF000001E2D, 2'b10, 1'b0);
        apply(64'h07070707070707FD, 8'hFF);
        check("term0", 64'h0000000000000087, 2'b10, 1'b0);
        apply(64'hFD77665544332211, 8'h80);
        check("term7", 64'h77665544332211FF, 2'b10, 1'b0);
        apply(64'hFE07070707FDBBAA, 8'hFC);
        check("term2_code", 64'h3C00000000BBAAAA, 2'b10, 1'b0);
        apply(64'h0707070707070707, 8'hFF);
        check("idle2", 64'h1E, 2'b10, 1'b0);
        apply(64'h070707070000019D, 8'hF1);
        check("bad_oset", ERR_BLK, 2'b10, 1'b1);
        apply(64'h07070AFD44332211, 8'hF0);
        check("bad_tail", ERR_BLK, 2'b10, 1'b1);

        rst = 1'b1;
        apply(64'h0011223344556677, 8'h00);
        check("reset_mid", 64'h1E, 2'b10, 1'b0);
        rst = 1'b0;
        apply(64'h8899AABBCCDDEEFF, 8'h00);
        check("post_reset", 64'h8899AABBCCDDEEFF, 2'b01, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
